// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster constants
// and the pixel type used by the colour stage.
package vga_pkg;

  localparam int CLK_DIV  = 4;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP
                          + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP
                          + V_SYNC + V_BP;

  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Next coordinate along one axis, wrapping at last.
  function automatic coord_t coord_inc(
    input coord_t c,
    input coord_t last
  );
    return (c == last) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/vga_pixel_strobe.sv
// vga_pixel_strobe: divides the board clock
// down to a one-clock pixel enable.
module vga_pixel_strobe #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK_100MHz,
  input  logic Reset,
  output logic PixelEn
);

  localparam int DW =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST =
    DW'(CLK_DIV - 1);

  logic [DW-1:0] r_d;
  logic [DW-1:0] w_d_nxt;
  logic          r_pix_en;

  // Next divider phase, wrapping after the last.
  always_comb begin
    w_d_nxt = (r_d == D_LAST) ? '0 : r_d + 1'b1;
  end

  // Phase counter; the strobe is registered so it
  // is high exactly while the phase sits at last.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      r_d      <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_d      <= w_d_nxt;
      r_pix_en <= (w_d_nxt == D_LAST);
    end
  end

  assign PixelEn = r_pix_en;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel/line counters plus
// registered active, start pulses and syncs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic               CLK_100MHz,
  input  logic               Reset,
  output logic               PixelEn,
  output logic [COORD_W-1:0] HCount,
  output logic [COORD_W-1:0] VCount,
  output logic               Active,
  output logic               LineStart,
  output logic               FrameStart,
  output logic               HSync,
  output logic               VSync
);

  localparam int HT = H_ACTIVE + H_FP
                    + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP
                    + V_SYNC + V_BP;

  localparam coord_t H_LAST = COORD_W'(HT - 1);
  localparam coord_t V_LAST = COORD_W'(VT - 1);
  localparam coord_t H_ACT  = COORD_W'(H_ACTIVE);
  localparam coord_t V_ACT  = COORD_W'(V_ACTIVE);
  localparam coord_t HS_BEG =
    COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END =
    COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG =
    COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END =
    COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic   w_pix_en;
  coord_t w_h_nxt;
  coord_t w_v_nxt;
  logic   w_h_wrap;
  logic   w_hs_in;
  logic   w_vs_in;

  coord_t r_h;
  coord_t r_v;
  logic   r_active;
  logic   r_ls;
  logic   r_fs;
  logic   r_hs;
  logic   r_vs;

  vga_pixel_strobe #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .CLK_100MHz (CLK_100MHz),
    .Reset      (Reset),
    .PixelEn    (w_pix_en)
  );

  // Next raster position and its sync windows.
  always_comb begin
    w_h_wrap = (r_h == H_LAST);
    w_h_nxt  = coord_inc(r_h, H_LAST);
    w_v_nxt  = w_h_wrap ? coord_inc(r_v, V_LAST)
                        : r_v;
    w_hs_in  = (w_h_nxt >= HS_BEG)
            && (w_h_nxt <  HS_END);
    w_vs_in  = (w_v_nxt >= VS_BEG)
            && (w_v_nxt <  VS_END);
  end

  // Advance position on each pixel strobe; decoded
  // outputs are registered from the next position
  // so they line up with the visible counters.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      r_h      <= H_LAST;
      r_v      <= V_LAST;
      r_active <= 1'b0;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
      r_hs     <= ~H_POL;
      r_vs     <= ~V_POL;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
      if (w_pix_en) begin
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_active <= (w_h_nxt < H_ACT)
                 && (w_v_nxt < V_ACT);
        r_ls     <= (w_h_nxt == '0);
        r_fs     <= (w_h_nxt == '0)
                 && (w_v_nxt == '0);
        r_hs     <= w_hs_in ? H_POL : ~H_POL;
        r_vs     <= w_vs_in ? V_POL : ~V_POL;
      end
    end
  end

  assign PixelEn    = w_pix_en;
  assign HCount     = r_h;
  assign VCount     = r_v;
  assign Active     = r_active;
  assign LineStart  = r_ls;
  assign FrameStart = r_fs;
  assign HSync      = r_hs;
  assign VSync      = r_vs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on the
// default raster and on a shrunken raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic       d_pe, d_act, d_ls, d_fs, d_hs, d_vs;
  logic [9:0] d_h, d_v;
  logic       s_pe, s_act, s_ls, s_fs, s_hs, s_vs;
  logic [9:0] s_h, s_v;
  logic       p_pe, p_act, p_ls, p_fs, p_hs, p_vs;
  logic [9:0] p_h, p_v;

  vga_timing_gen u_def (
    .CLK_100MHz (clk),  .Reset      (rst),
    .PixelEn    (d_pe), .HCount     (d_h),
    .VCount     (d_v),  .Active     (d_act),
    .LineStart  (d_ls), .FrameStart (d_fs),
    .HSync      (d_hs), .VSync      (d_vs)
  );

  // 15x8 raster: hsync 10..12, vsync 5..6
  vga_timing_gen #(
    .CLK_DIV (4),
    .H_ACTIVE (8), .H_FP (2),
    .H_SYNC (3),   .H_BP (2),
    .V_ACTIVE (4), .V_FP (1),
    .V_SYNC (2),   .V_BP (1)
  ) u_sml (
    .CLK_100MHz (clk),  .Reset      (rst),
    .PixelEn    (s_pe), .HCount     (s_h),
    .VCount     (s_v),  .Active     (s_act),
    .LineStart  (s_ls), .FrameStart (s_fs),
    .HSync      (s_hs), .VSync      (s_vs)
  );

  vga_timing_gen #(
    .CLK_DIV (4),
    .H_ACTIVE (8), .H_FP (2),
    .H_SYNC (3),   .H_BP (2),
    .V_ACTIVE (4), .V_FP (1),
    .V_SYNC (2),   .V_BP (1),
    .H_POL (1'b1), .V_POL (1'b1)
  ) u_pol (
    .CLK_100MHz (clk),  .Reset      (rst),
    .PixelEn    (p_pe), .HCount     (p_h),
    .VCount     (p_v),  .Active     (p_act),
    .LineStart  (p_ls), .FrameStart (p_fs),
    .HSync      (p_hs), .VSync      (p_vs)
  );

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d",
               tag, obs, exp);
    end
  endtask

  // Pulse reset for one clock at a chosen small
  // raster point, then expect FrameStart 4 clocks
  // after the first clock with reset low.
  task automatic mid_rst(
    input string tag,
    input int    th,
    input int    tv,
    input logic  want_pe
  );
    bit found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (int'(s_h) == th && int'(s_v) == tv
          && s_pe == want_pe)
        found = 1;
    end
    chk({tag, "_found"}, int'(found), 1);
    if (!found) return;
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_h"},   int'(s_h), 14);
    chk({tag, "_v"},   int'(s_v), 7);
    chk({tag, "_act"}, int'(s_act), 0);
    chk({tag, "_hs"},  int'(s_hs), 1);
    chk({tag, "_vs"},  int'(s_vs), 1);
    chk({tag, "_pe"},  int'(s_pe), 0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3)
        chk({tag, "_fs3"}, int'(s_fs), 0);
      if (k == 4) begin
        chk({tag, "_fs4"}, int'(s_fs), 1);
        chk({tag, "_h4"},  int'(s_h), 0);
        chk({tag, "_v4"},  int'(s_v), 0);
      end
    end
  endtask

  initial begin
    int n_act, n_hsl, n_pe, n_ls, max_h;
    int sv_l, s_a, s_av, s_fsn, s_lsn;
    int s_mh, s_mv, p_hh, p_vh, s_hsl;
    int p_hbad, p_vbad, fs_k, ph, pv;
    bit seen_w;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pe",  int'(d_pe),  0);
    chk("rst_h",   int'(d_h),   799);
    chk("rst_v",   int'(d_v),   524);
    chk("rst_act", int'(d_act), 0);
    chk("rst_ls",  int'(d_ls),  0);
    chk("rst_fs",  int'(d_fs),  0);
    chk("rst_hs",  int'(d_hs),  1);
    chk("rst_vs",  int'(d_vs),  1);
    chk("rst_phs", int'(p_hs),  0);
    chk("rst_pvs", int'(p_vs),  0);

    // Released inside clock 0 of the count.
    rst = 1'b0;
    n_act = 0; n_hsl = 0; n_pe = 0;
    n_ls = 0; max_h = 0;
    for (int k = 1; k <= 3204; k++) begin
      @(negedge clk);
      if (k == 2) chk("pe_c2", int'(d_pe), 0);
      if (k == 3) begin
        chk("pe_c3", int'(d_pe), 1);
        chk("h_c3",  int'(d_h), 799);
      end
      if (k == 4) begin
        chk("h_c4",   int'(d_h),   0);
        chk("v_c4",   int'(d_v),   0);
        chk("ls_c4",  int'(d_ls),  1);
        chk("fs_c4",  int'(d_fs),  1);
        chk("act_c4", int'(d_act), 1);
      end
      if (k == 5) begin
        chk("fs_c5", int'(d_fs), 0);
        chk("ls_c5", int'(d_ls), 0);
        chk("h_c5",  int'(d_h),  0);
      end
      if (k >= 4 && k <= 3203) begin
        if (d_act) n_act++;
        if (!d_hs) n_hsl++;
        if (d_pe)  n_pe++;
        if (d_ls)  n_ls++;
        if (int'(d_h) > max_h) max_h = int'(d_h);
      end
      if (k == 3204) begin
        chk("line_ls", int'(d_ls), 1);
        chk("line_h",  int'(d_h),  0);
        chk("line_v",  int'(d_v),  1);
      end
    end
    chk("line_act", n_act, 2560);
    chk("line_hsl", n_hsl, 384);
    chk("line_pe",  n_pe,  800);
    chk("line_lsn", n_ls,  1);
    chk("line_maxh", max_h, 799);

    // Whole frame on the shrunken raster.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sv_l = 0; s_a = 0; s_av = 0; s_fsn = 0;
    s_lsn = 0; s_mh = 0; s_mv = 0; p_hh = 0;
    p_vh = 0; s_hsl = 0; p_hbad = 0;
    p_vbad = 0; fs_k = -1; ph = 0; pv = 0;
    seen_w = 0;
    for (int k = 1; k <= 484; k++) begin
      @(negedge clk);
      if (s_ls && ph == 14 && pv == 6) begin
        seen_w = 1;
        chk("w6_v",  int'(s_v),  7);
        chk("w6_h",  int'(s_h),  0);
        chk("w6_fs", int'(s_fs), 0);
      end
      if (s_fs) begin
        if (fs_k >= 0)
          chk("fs_period", k - fs_k, 480);
        fs_k = k;
      end
      if (k >= 4 && k <= 483) begin
        if (!s_vs) sv_l++;
        if (!s_hs) s_hsl++;
        if (s_act) s_a++;
        if (s_act && s_v >= 10'd4) s_av++;
        if (s_fs) s_fsn++;
        if (s_ls) s_lsn++;
        if (int'(s_h) > s_mh) s_mh = int'(s_h);
        if (int'(s_v) > s_mv) s_mv = int'(s_v);
        if (p_hs) p_hh++;
        if (p_vs) p_vh++;
        if (p_hs != (p_h >= 10'd10
                     && p_h <= 10'd12))
          p_hbad++;
        if (p_vs != (p_v >= 10'd5
                     && p_v <= 10'd6))
          p_vbad++;
      end
      if (k == 484) begin
        chk("wf_fs", int'(s_fs), 1);
        chk("wf_h",  int'(s_h),  0);
        chk("wf_v",  int'(s_v),  0);
        chk("wf_ph", ph, 14);
        chk("wf_pv", pv, 7);
      end
      ph = int'(s_h);
      pv = int'(s_v);
    end
    chk("w6_seen",  int'(seen_w), 1);
    chk("fr_vsl",   sv_l,  120);
    chk("fr_hsl",   s_hsl, 96);
    chk("fr_act",   s_a,   128);
    chk("fr_actv",  s_av,  0);
    chk("fr_fsn",   s_fsn, 1);
    chk("fr_lsn",   s_lsn, 8);
    chk("fr_maxh",  s_mh,  14);
    chk("fr_maxv",  s_mv,  7);
    chk("pol_hh",   p_hh,  96);
    chk("pol_vh",   p_vh,  120);
    chk("pol_hbad", p_hbad, 0);
    chk("pol_vbad", p_vbad, 0);

    mid_rst("mid", 5, 3, 1'b0);
    mid_rst("coin", 9, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d",
             n_chk, n_err);
    $finish;
  end

endmodule
